// File: rtl/rf_multiport_sb.sv
// rf_multiport_sb: integer register file with NRD combinational read ports,
// two write ports (port 1 wins on an address collision), optional same-cycle
// write-to-read bypass and a one-bit-per-register pending scoreboard.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   rd_addr  [NRD*AW]     read addresses, port k at [k*AW +: AW]
//   rd_data  [NRD*DATA_W] read data, port k at [k*DATA_W +: DATA_W]
//   rd_pending [NRD]      register on port k still has an outstanding producer
//   wr_en [2], wr_addr [2*AW], wr_data [2*DATA_W]   writeback ports 0 and 1
//   sb_set, sb_addr       mark sb_addr pending at the next edge (issue)
//   sb_busy_any           OR of all scoreboard bits (drain indicator)

// One read port: address decode, bypass select and pending lookup.
module rf_rd_port #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int AW       = 5,
    parameter int BYPASS   = 1
) (
    input  logic                             reset,
    input  logic [AW-1:0]                    addr,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
    input  logic [NUM_REGS-1:0]              sb,
    input  logic [1:0]                       wr_en,
    input  logic [1:0][AW-1:0]               wr_addr,
    input  logic [1:0][DATA_W-1:0]           wr_data,
    output logic [DATA_W-1:0]                data,
    output logic                             pending
);
    logic [1:0] hit;

    always_comb begin
        hit = '0;
        // Forwarding is gated by reset so outputs read zero while held in reset.
        for (int p = 0; p < 2; p++)
            hit[p] = (BYPASS != 0) && !reset && wr_en[p] &&
                     (wr_addr[p] == addr) && (addr != '0);
        // r0 storage and its scoreboard bit are never written, so they read 0.
        data    = regs[addr];
        pending = sb[addr];
        // Forwarded data resolves the hazard, so pending is dropped with it.
        if (hit[1]) begin
            data    = wr_data[1];
            pending = 1'b0;
        end else if (hit[0]) begin
            data    = wr_data[0];
            pending = 1'b0;
        end
    end
endmodule

module rf_multiport_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_pending,
    input  logic [1:0]            wr_en,
    input  logic [2*AW-1:0]       wr_addr,
    input  logic [2*DATA_W-1:0]   wr_data,
    input  logic                  sb_set,
    input  logic [AW-1:0]         sb_addr,
    output logic                  sb_busy_any
);
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]             sb, sb_nxt;
    logic [1:0][AW-1:0]              wa;
    logic [1:0][DATA_W-1:0]          wd;
    logic [NRD-1:0][AW-1:0]          ra;
    logic [NRD-1:0][DATA_W-1:0]      rd;

    assign wa      = wr_addr;
    assign wd      = wr_data;
    assign ra      = rd_addr;
    assign rd_data = rd;

    // Clears first, then the set: a new producer issued in the same cycle
    // supersedes the one completing, so the bit ends up set.
    always_comb begin
        sb_nxt = sb;
        for (int p = 0; p < 2; p++)
            if (wr_en[p]) sb_nxt[wa[p]] = 1'b0;
        if (sb_set) sb_nxt[sb_addr] = 1'b1;
        sb_nxt[0] = 1'b0;
    end

    // Port 1 is written last so it overrides port 0 on the same address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs <= '0;
            sb   <= '0;
        end else begin
            for (int p = 0; p < 2; p++)
                if (wr_en[p] && wa[p] != '0) regs[wa[p]] <= wd[p];
            sb <= sb_nxt;
        end
    end

    assign sb_busy_any = |sb;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        rf_rd_port #(
            .DATA_W  (DATA_W),
            .NUM_REGS(NUM_REGS),
            .AW      (AW),
            .BYPASS  (BYPASS)
        ) u_port (
            .reset  (reset),
            .addr   (ra[k]),
            .regs   (regs),
            .sb     (sb),
            .wr_en  (wr_en),
            .wr_addr(wa),
            .wr_data(wd),
            .data   (rd[k]),
            .pending(rd_pending[k])
        );
    end
endmodule
